// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Package  : i2c_pkg
// Brief    : Shared state encoding, quarter-phase indices and the default
//            slave address for the single-byte I2C write master.
// Revision : 1.0 - initial release
// ============================================================================
package i2c_pkg;

  // FSM state encoding
  typedef logic [2:0] state_t;

  localparam state_t c_st_idle  = 3'd0;
  localparam state_t c_st_start = 3'd1;
  localparam state_t c_st_addr  = 3'd2;
  localparam state_t c_st_ack1  = 3'd3;
  localparam state_t c_st_data  = 3'd4;
  localparam state_t c_st_ack2  = 3'd5;
  localparam state_t c_st_stop  = 3'd6;

  // Quarter-bit phase indices within one SCL period
  localparam logic [1:0] c_q0 = 2'd0;
  localparam logic [1:0] c_q1 = 2'd1;
  localparam logic [1:0] c_q2 = 2'd2;
  localparam logic [1:0] c_q3 = 2'd3;

  // PCF8574 CLCD backpack
  localparam logic [6:0] c_default_addr = 7'h27;

endpackage
`default_nettype wire

// File: rtl/i2c_qtr_tick.sv
`default_nettype none
// ============================================================================
// Module   : i2c_qtr_tick
// Brief    : Quarter-bit timebase. Emits a one-cycle tick every QTR clocks
//            while enabled and tracks which of the four quarters is active.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_qtr_tick #(
  parameter int QTR = 250
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       i_en,
  input  logic       i_restart,
  output logic       o_tick,
  output logic [1:0] o_qtr
);

  localparam int              c_cw   = (QTR > 2) ? $clog2(QTR) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(QTR - 1);

  logic [c_cw-1:0] r_cnt;
  logic [1:0]      r_qtr;

  // Restart wins so a fresh transaction always begins at quarter 0, count 0
  assign o_tick = i_en && !i_restart && (r_cnt == c_last);
  assign o_qtr  = r_qtr;

  // Free-running quarter counter, frozen while disabled
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_cnt <= '0;
      r_qtr <= c_q0_val();
    end else if (i_restart) begin
      r_cnt <= '0;
      r_qtr <= c_q0_val();
    end else if (i_en) begin
      if (r_cnt == c_last) begin
        r_cnt <= '0;
        r_qtr <= r_qtr + 2'd1;
      end else begin
        r_cnt <= r_cnt + c_cw'(1);
      end
    end
  end

  function automatic logic [1:0] c_q0_val();
    return 2'd0;
  endfunction

endmodule
`default_nettype wire

// File: rtl/i2c_master_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master_tx
// Brief    : Write-only single-byte I2C master: START, address+R/W, ACK,
//            data byte, ACK, STOP. Push-pull SCL, open-drain SDA.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_master_tx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int SCL_FREQ = 100_000
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic [6:0] i_addr,
  input  logic [7:0] i_data,
  input  logic       i_RW,
  input  logic       i_valid,
  output logic       o_busy,
  output logic       o_ack_err,
  output logic       o_scl,
  inout  wire        io_sda
);

  import i2c_pkg::*;

  localparam int c_qtr = CLK_FREQ / (4 * SCL_FREQ);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0] r_addr_sr, w_addr_sr_nxt;
  logic [7:0] r_data_sr, w_data_sr_nxt;
  logic       r_ack_err, w_ack_err_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_scl, w_scl_nxt;
  logic       r_sda_oe, w_sda_oe_nxt;
  logic       w_tick;
  logic [1:0] w_qtr, w_qtr_nxt;
  logic       w_accept, w_q_end, w_ack_smp;

  i2c_qtr_tick #(
    .QTR (c_qtr)
  ) u_qtr_tick (
    .clk       (clk),
    .reset_p   (reset_p),
    .i_en      (r_busy),
    .i_restart (w_accept),
    .o_tick    (w_tick),
    .o_qtr     (w_qtr)
  );

  assign w_accept  = (r_state == c_st_idle) && i_valid;
  assign w_q_end   = w_tick && (w_qtr == c_q3);
  assign w_ack_smp = w_tick && (w_qtr == c_q2);
  // Quarter index as it will read after this edge; drives the registered outputs
  assign w_qtr_nxt = w_accept ? c_q0 : (w_tick ? w_qtr + 2'd1 : w_qtr);

  // State register
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) r_state <= c_st_idle;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic: every phase lasts whole SCL periods, so moves happen at q3 end
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (i_valid) w_state_nxt = c_st_start;
      c_st_start: if (w_q_end) w_state_nxt = c_st_addr;
      c_st_addr:  if (w_q_end && (r_bit_cnt == 3'd7)) w_state_nxt = c_st_ack1;
      c_st_ack1:  if (w_q_end) w_state_nxt = r_ack_err ? c_st_stop : c_st_data;
      c_st_data:  if (w_q_end && (r_bit_cnt == 3'd7)) w_state_nxt = c_st_ack2;
      c_st_ack2:  if (w_q_end) w_state_nxt = c_st_stop;
      c_st_stop:  if (w_q_end) w_state_nxt = c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  // Datapath next values: latch on acceptance, shift per bit, sample ACK at q2->q3
  always_comb begin
    w_addr_sr_nxt = r_addr_sr;
    w_data_sr_nxt = r_data_sr;
    w_bit_cnt_nxt = r_bit_cnt;
    w_ack_err_nxt = r_ack_err;
    if (w_accept) begin
      w_addr_sr_nxt = {i_addr, i_RW};
      w_data_sr_nxt = i_data;
      w_bit_cnt_nxt = 3'd0;
      w_ack_err_nxt = 1'b0;
    end else begin
      case (r_state)
        c_st_addr: if (w_q_end) begin
          w_addr_sr_nxt = {r_addr_sr[6:0], 1'b0};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
        end
        c_st_data: if (w_q_end) begin
          w_data_sr_nxt = {r_data_sr[6:0], 1'b0};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
        end
        c_st_ack1, c_st_ack2: if (w_ack_smp && io_sda) w_ack_err_nxt = 1'b1;
        default: ;
      endcase
    end
  end

  // Output decode from the upcoming state/quarter so the bus pins are registered
  always_comb begin
    w_scl_nxt    = 1'b1;
    w_sda_oe_nxt = 1'b0;
    w_busy_nxt   = (w_state_nxt != c_st_idle);
    case (w_state_nxt)
      c_st_start: begin
        w_scl_nxt    = (w_qtr_nxt != c_q3);
        w_sda_oe_nxt = (w_qtr_nxt == c_q2) || (w_qtr_nxt == c_q3);
      end
      c_st_addr: begin
        w_scl_nxt    = w_qtr_nxt[1];
        w_sda_oe_nxt = ~w_addr_sr_nxt[7];
      end
      c_st_data: begin
        w_scl_nxt    = w_qtr_nxt[1];
        w_sda_oe_nxt = ~w_data_sr_nxt[7];
      end
      c_st_ack1, c_st_ack2: begin
        w_scl_nxt    = w_qtr_nxt[1];
        w_sda_oe_nxt = 1'b0;
      end
      c_st_stop: begin
        w_scl_nxt    = (w_qtr_nxt != c_q0);
        w_sda_oe_nxt = (w_qtr_nxt == c_q0) || (w_qtr_nxt == c_q1);
      end
      default: ;
    endcase
  end

  // Datapath and bus output registers
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_addr_sr <= 8'h00;
      r_data_sr <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_ack_err <= 1'b0;
      r_busy    <= 1'b0;
      r_scl     <= 1'b1;
      r_sda_oe  <= 1'b0;
    end else begin
      r_addr_sr <= w_addr_sr_nxt;
      r_data_sr <= w_data_sr_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_ack_err <= w_ack_err_nxt;
      r_busy    <= w_busy_nxt;
      r_scl     <= w_scl_nxt;
      r_sda_oe  <= w_sda_oe_nxt;
    end
  end

  assign o_busy    = r_busy;
  assign o_ack_err = r_ack_err;
  assign o_scl     = r_scl;
  assign io_sda    = r_sda_oe ? 1'b0 : 1'bz;

endmodule
`default_nettype wire

// File: doc/i2c_master_tx.md
# i2c_master_tx

Write-only, single-byte I2C master that sits directly downstream of the keypad-to-CLCD formatter. Each accepted request emits one bus transaction: START, 7-bit address plus R/W bit, ACK slot, one data byte, ACK slot, STOP. `o_busy` spans the whole transaction, so the upstream stage can drop `i_valid` on busy's rising edge and pace itself on busy's falling edge. The target is the PCF8574 CLCD backpack at address 0x27; no clock stretching and no multi-master arbitration.

## Interface
- `CLK_FREQ`, default 100_000_000: system clock in Hz.
- `SCL_FREQ`, default 100_000: bus clock in Hz. `QTR = CLK_FREQ/(4*SCL_FREQ)` clk cycles per quarter-bit, 250 at defaults. `QTR` ≥ 2 is required.
- `clk` (in, 1): single clock; all logic on posedge.
- `reset_p` (in, 1): asynchronous, active-high reset.
- `i_addr` (in, 7): slave address.
- `i_data` (in, 8): payload byte.
- `i_RW` (in, 1): transmitted verbatim as the address-byte LSB. Only 0 is supported; the data phase is always a write.
- `i_valid` (in, 1): request strobe, level-sampled.
- `o_busy` (out, 1): transaction in progress.
- `o_ack_err` (out, 1): NACK seen in the last transaction.
- `o_scl` (out, 1): push-pull bus clock.
- `io_sda` (inout, 1): open-drain data line; drives 0 or Z, never 1.

## Operation
- Reset values: `o_busy`=0, `o_ack_err`=0, `o_scl`=1, `io_sda`=Z, state=IDLE, tick counter=0.
- Reset mid-transaction aborts immediately and asynchronously to the reset values. No STOP is generated.
- IDLE, `i_valid`=1:
  - latch `{i_addr,i_RW}` into a shift register and `i_data` into a second register;
  - set `o_busy`=1 and clear `o_ack_err` on the same edge;
  - restart the quarter counter;
  - go to START.
- `i_valid` is ignored whenever state≠IDLE. Input changes after acceptance have no effect.
- State machine (each state advances on quarter ticks):
  - START (4 qtrs): SCL=1 throughout q0–q2; SDA released q0–q1, low q2–q3; SCL low at q3.
  - ADDR (8 bits × 4 qtrs), MSB first. Per bit: q0 SCL=0 and SDA set; q1 SCL=0; q2–q3 SCL=1.
  - ACK1 (4 qtrs): SDA released; sample `io_sda` at the q2→q3 boundary. 0 → DATA. 1 → set `o_ack_err` and go to STOP, skipping DATA.
  - DATA (8 bits × 4 qtrs): same bit timing as ADDR.
  - ACK2 (4 qtrs): sampled as in ACK1; 1 → set `o_ack_err`; always go to STOP.
  - STOP (4 qtrs): q0 SCL=0, SDA low; q1 SCL=1, SDA low; q2 SDA released; q3 bus idle, which serves as the bus-free gap.
  - End of STOP q3 → IDLE, `o_busy`=0.
- SDA changes only while SCL=0, except the START and STOP edges.
- The bit counter is 3 bits and wraps 7→0 on each byte-to-ACK transition.
- `o_ack_err` holds until the next acceptance.

## Timing
- Acceptance latency: `o_busy` rises on the first posedge where IDLE && `i_valid`.
- Busy duration:
  - ACK path: START 4 + ADDR/ACK 36 + DATA/ACK 36 + STOP 4 = 80 quarters = 80·QTR cycles (20 000 at defaults).
  - NACK at ACK1: 44·QTR cycles.
- `o_busy` falls on the edge that enters IDLE. A request held high at that edge is accepted no earlier than the next edge, so busy shows at least one low cycle between transactions.
- The quarter tick is a 1-cycle pulse every QTR cycles, free-running only while busy.
- `o_scl` and the SDA output enable are registered, with no combinational path from inputs.

## Structure
- `i2c_pkg`:
  - state encoding: IDLE, START, ADDR, ACK1, DATA, ACK2, STOP;
  - the quarter-phase constants;
  - the default address `7'h27`.
- One sub-module, `i2c_qtr_tick`: parameterised QTR counter with enable and synchronous restart, outputs `tick` and a 2-bit `qtr` index.
- The top level holds the FSM, shift registers, 3-bit bit counter and SDA tri-state.

## Test plan
Parameters `CLK_FREQ=4000`, `SCL_FREQ=100`, giving QTR=10. Slave model acks unless told otherwise.
- Write to 0x27, data 0xD5, ACKs: SDA bytes decoded as 0x4E and 0xD5; `o_busy` high exactly 800 cycles; `o_ack_err`=0.
- Same write, slave NACKs address: `o_ack_err`=1; no DATA bits clocked; busy 440 cycles; STOP observed.
- NACK on data byte: `o_ack_err`=1 after the full 800-cycle transaction. A following ACKed transaction clears it at acceptance.
- `i_valid` held high continuously: back-to-back transactions separated by exactly 1 busy-low cycle. `i_data` changed mid-transaction does not alter the transmitted byte.
- `reset_p` asserted in the middle of the DATA phase: same cycle gives `o_scl`=1, `io_sda`=Z, `o_busy`=0. The next request starts cleanly with START.
- Protocol checker over all tests: SDA never changes while SCL=1 except START and STOP; `io_sda` never driven to 1.
